cube_root_seq: RTL and testbench
================================

Name: cube_root_seq

Overview:
- Sequential replacement for the combinational cube-root calculation that feeds the 7-segment display multiplexer.
- Computes floor(cbrt(number) * 100) with an iterative digit-by-digit engine, one step per clock.
- Converts the 10-bit result to three BCD digits with a double-dabble engine.
- Presents the digits to the display stage, stable between updates, with a done pulse.

Parameters:
- IN_W, 8, width of the input operand; legal 1..8. The operand is zero-extended to 8 bits internally.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a computation; sampled only in IDLE
- number  in  IN_W  unsigned operand; captured on the start-accept edge
- busy  out  1  high while a computation is in progress
- done  out  1  one-cycle pulse when the digit outputs update
- digit_int  out  4  BCD integer digit (display position with decimal point)
- digit_tenth  out  4  BCD first fractional digit
- digit_hund  out  4  BCD second fractional digit

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE; busy=0, done=0.
  - All digit outputs 0.
  - Internal x, y, iteration counter and shift registers cleared.
- Reset mid-operation aborts the computation. No done pulse, digits go to 0.
- States: IDLE, ROOT, BCD, DONE.
- IDLE:
  - On start=1 at a rising edge: x <= number*1_000_000 (32 bit, max 255_000_000), y <= 0, s <= 30, go to ROOT, busy <= 1.
  - number is ignored after capture.
- ROOT, 11 cycles, s = 30, 27, ..., 0. Each cycle:
  - y2 = 2*y
  - b = (3*y2*(y2+1)+1) << s, computed in 64 bits
  - if zero-extended x >= b: x <= x-b, y <= y2+1; else y <= y2
  - s <= s-3
- After the s=0 step, go to BCD. y fits in 10 bits (max 634); bits above [9:0] are guaranteed zero.
- BCD, 10 cycles, double dabble on y[9:0] into a 12-bit BCD register. Each cycle:
  - add 3 to any nibble >= 5
  - then shift left one bit, bringing in the next MSB of y
- After 10 shifts, go to DONE.
- DONE, 1 cycle:
  - Digit outputs load from the BCD register (hundreds->digit_int, tens->digit_tenth, ones->digit_hund).
  - done=1 this cycle only; busy <= 0; next state IDLE.
- Latency: start accepted at edge E0. ROOT occupies cycles 1-11, BCD cycles 12-21, done high in cycle 22. A new start is accepted at the earliest in cycle 23.
- start while busy is ignored, not queued.
- start held high continuously gives back-to-back computations, one every 23 cycles.
- Digit outputs change only on the done edge. They hold their value otherwise, including during a new computation.
- All outputs are registered. No combinational path from inputs to outputs.

Optional Feature:
- Macro: CUBE_ROOT_AUTO_START_EN.
- Defined:
  - Add a register last_number, reset 0, written on every accept.
  - In IDLE, a computation is also launched when number != last_number, with no start needed.
  - An explicit start still works.
  - The display tracks the switches without a strobe.
- Undefined: computations launch only on start. last_number does not exist.

Test Plan:
- Reset values: rst_n low for 3 cycles -> busy=0, done=0, digits 0/0/0. Release, start idle -> outputs unchanged for 50 cycles.
- Exact root: number=8, start pulse -> busy for 22 cycles, done in cycle 22, digits 2/0/0. number=1 -> 1/0/0. number=0 -> 0/0/0.
- Truncation: number=255 -> 6/3/4. number=10 -> 2/1/5. number=100 -> 4/6/4.
- Busy handling: start at E0 with number=27, start again at cycle 5 with number=64 -> single done at cycle 22 with 3/0/0, no second done. Digits hold 3/0/0 until the next accepted start completes.
- Reset mid-operation: start number=200, rst_n low at cycle 10 -> immediate busy=0 and digits 0/0/0. No done. A fresh start of number=200 -> 5/8/4.
- Auto start (macro defined): after reset, set number=125 without start -> done 23 cycles later with 5/0/0. number held -> no further done. Change to 64 -> new done with 4/0/0.

Source files
------------

// File: rtl/cube_root_seq.sv
// ============================================================================
// cube_root_seq : floor(cbrt(number)*100) by digit-by-digit root + double dabble
// Optional: CUBE_ROOT_AUTO_START_EN relaunches on operand change.  Rev 1.0
// ============================================================================
`default_nettype none

module cube_root_seq #(
  parameter int IN_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [IN_W-1:0] number,
  output logic            busy,
  output logic            done,
  output logic [3:0]      digit_int,
  output logic [3:0]      digit_tenth,
  output logic [3:0]      digit_hund
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROOT = 2'd1,
    S_BCD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t       r_state, w_next;
  logic [31:0]  r_x;
  logic [9:0]   r_y;
  logic [4:0]   r_s;
  logic [3:0]   r_cnt;
  logic [21:0]  r_dd;     // {bcd[11:0], binary[9:0]} double-dabble shifter

  logic [7:0]   w_num8;
  logic         w_accept;
  logic [63:0]  w_y2, w_y2p1, w_b;
  logic         w_ge;
  logic [9:0]   w_y_new;
  logic [11:0]  w_adj;
  logic [21:0]  w_dd_next;

  assign w_num8 = 8'(number);

`ifdef CUBE_ROOT_AUTO_START_EN
  logic [7:0] r_last_number;
  assign w_accept = (r_state == S_IDLE) && (start || (w_num8 != r_last_number));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_last_number <= 8'd0;
    else if (w_accept) r_last_number <= w_num8;
  end
`else
  assign w_accept = (r_state == S_IDLE) && start;
`endif

  // One root step: try appending a 1 bit to y against the remaining radicand
  assign w_y2    = {53'd0, r_y, 1'b0};
  assign w_y2p1  = w_y2 + 64'd1;
  assign w_b     = (64'd3 * w_y2 * w_y2p1 + 64'd1) << r_s;
  assign w_ge    = {32'd0, r_x} >= w_b;
  assign w_y_new = w_ge ? w_y2p1[9:0] : w_y2[9:0];

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign w_adj     = {add3(r_dd[21:18]), add3(r_dd[17:14]), add3(r_dd[13:10])};
  assign w_dd_next = {w_adj, r_dd[9:0]} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ROOT;
      S_ROOT:  if (r_s == 5'd0) w_next = S_BCD;
      S_BCD:   if (r_cnt == 4'd9) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x         <= 32'd0;
      r_y         <= 10'd0;
      r_s         <= 5'd0;
      r_cnt       <= 4'd0;
      r_dd        <= 22'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      digit_int   <= 4'd0;
      digit_tenth <= 4'd0;
      digit_hund  <= 4'd0;
    end else begin
      busy <= (w_next != S_IDLE);
      done <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_x   <= 32'(w_num8) * 32'd1_000_000;
          r_y   <= 10'd0;
          r_s   <= 5'd30;
          r_cnt <= 4'd0;
          r_dd  <= 22'd0;
        end
        S_ROOT: begin
          if (w_ge) r_x <= r_x - w_b[31:0];
          r_y <= w_y_new;
          r_s <= r_s - 5'd3;
          if (r_s == 5'd0) r_dd <= {12'd0, w_y_new};
        end
        S_BCD: begin
          r_dd  <= w_dd_next;
          r_cnt <= r_cnt + 4'd1;
          // Digits update only on the edge that enters DONE, alongside the pulse
          if (r_cnt == 4'd9) begin
            digit_int   <= w_dd_next[21:18];
            digit_tenth <= w_dd_next[17:14];
            digit_hund  <= w_dd_next[13:10];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cube_root_seq.sv
// Directed self-checking bench for cube_root_seq (default and auto-start builds).
`default_nettype none

module tb_cube_root_seq;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [7:0] number;
  logic       busy, done;
  logic [3:0] digit_int, digit_tenth, digit_hund;

  int n_assert = 0;
  int n_fail   = 0;
  logic [11:0] prev_digits;

  cube_root_seq #(.IN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .number(number),
    .busy(busy), .done(done),
    .digit_int(digit_int), .digit_tenth(digit_tenth), .digit_hund(digit_hund)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] digs();
    return {digit_int, digit_tenth, digit_hund};
  endfunction

  task automatic run_calc(input string tag, input logic [7:0] num, input logic [11:0] exp_d);
    int cnt;
    number = num;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    chk({tag, "_digits_hold"}, 32'(digs()), 32'(prev_digits));
    cnt = 0;
    while (done !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    chk({tag, "_latency"}, cnt, 32'd21);
    chk({tag, "_digits"}, 32'(digs()), 32'(exp_d));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    prev_digits = exp_d;
  endtask

  initial begin
    int cnt;
    int ev;
    rst_n = 1'b0;
    start = 1'b0;
    number = 8'd0;
    prev_digits = 12'h000;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_digits", 32'(digs()), 32'h000);

    rst_n = 1'b1;
    ev = 0;
    repeat (50) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) ev++;
    end
    chk("idle_no_activity", ev, 32'd0);
    chk("idle_digits", 32'(digs()), 32'h000);

    run_calc("n8",   8'd8,   12'h200);
    run_calc("n1",   8'd1,   12'h100);
    run_calc("n0",   8'd0,   12'h000);
    run_calc("n255", 8'd255, 12'h634);
    run_calc("n10",  8'd10,  12'h215);
    run_calc("n100", 8'd100, 12'h464);
    run_calc("n2",   8'd2,   12'h125);
    run_calc("n3",   8'd3,   12'h144);

    // Start while busy must be ignored
    number = 8'd27;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (3) tick();
    number = 8'd64;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    number = 8'd27;
    cnt = 4;
    while (done !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("busy_ign_latency", cnt, 32'd21);
    chk("busy_ign_digits", 32'(digs()), 32'h300);
    ev = 0;
    repeat (40) begin
      tick();
      if (done !== 1'b0) ev++;
    end
    chk("busy_ign_no_second_done", ev, 32'd0);
    chk("busy_ign_digits_hold", 32'(digs()), 32'h300);
    prev_digits = 12'h300;

    // Reset in the middle of a computation
    number = 8'd200;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (9) tick();
    rst_n  = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_digits", 32'(digs()), 32'h000);
    number = 8'd0;
    ev = 0;
    repeat (3) begin
      tick();
      if (done !== 1'b0) ev++;
    end
    rst_n = 1'b1;
    repeat (25) begin
      tick();
      if (done !== 1'b0) ev++;
    end
    chk("midrst_no_done", ev, 32'd0);
    prev_digits = 12'h000;
    run_calc("n200", 8'd200, 12'h584);

`ifdef CUBE_ROOT_AUTO_START_EN
    number = 8'd125;
    cnt = 0;
    while (done !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("auto125_latency", cnt, 32'd22);
    chk("auto125_digits", 32'(digs()), 32'h500);
    ev = 0;
    repeat (40) begin
      tick();
      if (done !== 1'b0) ev++;
    end
    chk("auto_hold_no_done", ev, 32'd0);
    number = 8'd64;
    cnt = 0;
    while (done !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("auto64_latency", cnt, 32'd22);
    chk("auto64_digits", 32'(digs()), 32'h400);
`else
    number = 8'd125;
    ev = 0;
    repeat (40) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) ev++;
    end
    chk("no_auto_launch", ev, 32'd0);
    chk("no_auto_digits_hold", 32'(digs()), 32'h584);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
